// File: rtl/chirp_pkg.sv
// Shared definitions for the linear-FM chirp phase generator: default widths,
// the default chirp rate and the controller state encoding.
package chirp_pkg;

    localparam int DEFAULT_PHASE_W = 48;
    localparam int DEFAULT_OUT_W   = 16;

    // 2^35-1: a slow up-chirp whose frequency crosses half-scale after 4096 samples
    localparam logic [DEFAULT_PHASE_W-1:0] DEFAULT_RATE = 48'h0007_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/chirp_gen_if.sv
// Phase-word stream from the chirp generator toward the sine ROM.
interface chirp_gen_if #(
    parameter int OUT_W = 16
) ();

    logic             phase_tvalid;
    logic [OUT_W-1:0] phase_tdata;

    modport master (output phase_tvalid, phase_tdata);
    modport slave  (input  phase_tvalid, phase_tdata);

endinterface

// File: rtl/chirp_gen_strobe_div.sv
// Free-running 0..DIV-1 counter producing a one-cycle strobe on the last count;
// held at zero while disabled so every run starts from a known phase.
module strobe_div #(
    parameter int DIV = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic strobe
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign strobe = en && (count == LAST);

endmodule

// File: rtl/chirp_gen.sv
// Chirp phase generator: a second-order accumulator (freq += rate, phase += freq)
// stepped once per strobe, emitting SWEEP_LEN phase words per sweep.
module chirp_gen
    import chirp_pkg::*;
#(
    parameter int PHASE_W    = DEFAULT_PHASE_W,
    parameter int OUT_W      = DEFAULT_OUT_W,
    parameter int STROBE_DIV = 7,
    parameter int SWEEP_LEN  = 8192,
    parameter int GAP_LEN    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [PHASE_W-1:0] rate_in,
    chirp_gen_if.master        rom,
    output logic               busy,
    output logic               sweep_done,
    output logic               freq_msb,
    output logic [15:0]        sweep_count
);

    localparam int CNT_W = 21;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SWEEP_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_GAP    = CNT_W'(GAP_LEN - 1);

    state_t             state;
    logic [PHASE_W-1:0] rate_q;
    logic               cont_q;
    logic [PHASE_W-1:0] freq;
    logic [PHASE_W-1:0] acc;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   gap_cnt;
    logic               end_pend;
    logic               tvalid;
    logic [OUT_W-1:0]   tdata;
    logic               strobe;

    strobe_div #(.DIV(STROBE_DIV)) u_strobe_div (
        .clk    (clk),
        .rst    (rst),
        .en     (busy),
        .strobe (strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rate_q      <= '0;
            cont_q      <= 1'b0;
            freq        <= '0;
            acc         <= '0;
            sample_cnt  <= '0;
            gap_cnt     <= '0;
            end_pend    <= 1'b0;
            tvalid      <= 1'b0;
            tdata       <= '0;
            sweep_done  <= 1'b0;
            sweep_count <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only in the
            // branch that fires, keeping them exactly one cycle wide.
            tvalid     <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        rate_q     <= rate_in;
                        cont_q     <= continuous;
                        freq       <= '0;
                        acc        <= '0;
                        sample_cnt <= '0;
                        gap_cnt    <= '0;
                        end_pend   <= 1'b0;
                        state      <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (stop) begin
                        end_pend <= 1'b0;
                        state    <= IDLE;
                    end else if (end_pend) begin
                        // Cycle after the last sample: report, then repeat or retire.
                        end_pend    <= 1'b0;
                        sweep_done  <= 1'b1;
                        sweep_count <= sweep_count + 1'b1;
                        sample_cnt  <= '0;
                        gap_cnt     <= '0;
                        if (!cont_q) begin
                            state <= IDLE;
                        end else if (GAP_LEN == 0) begin
                            freq <= '0;
                            acc  <= '0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (strobe) begin
                        tvalid     <= 1'b1;
                        tdata      <= acc[PHASE_W-1 -: OUT_W];
                        freq       <= freq + rate_q;
                        acc        <= acc + freq;
                        sample_cnt <= sample_cnt + 1'b1;
                        end_pend   <= (sample_cnt == LAST_SAMPLE);
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (strobe) begin
                        if (gap_cnt == LAST_GAP) begin
                            freq       <= '0;
                            acc        <= '0;
                            sample_cnt <= '0;
                            state      <= SWEEP;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign freq_msb         = freq[PHASE_W-1];
    assign rom.phase_tvalid = tvalid;
    assign rom.phase_tdata  = tdata;

endmodule

// File: tb/tb_chirp_gen.sv
// Directed bench for chirp_gen: short sweeps (single, aborted, continuous with and
// without gap, reset, down-chirp) plus one full 8192-sample sweep against a closed-form model.
module tb_chirp_gen;
    import chirp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic [47:0] rate = DEFAULT_RATE;

    logic        busy_a, done_a, msb_a;
    logic [15:0] count_a;
    logic        busy_b, done_b, msb_b;
    logic [15:0] count_b;
    logic        busy_c, done_c, msb_c;
    logic [15:0] count_c;

    chirp_gen_if #(.OUT_W(16)) rom_a ();
    chirp_gen_if #(.OUT_W(16)) rom_b ();
    chirp_gen_if #(.OUT_W(16)) rom_c ();

    int checks = 0;
    int errors = 0;

    logic [15:0] up_tbl [4] = '{16'h0000, 16'h0000, 16'h0007, 16'h0017};
    logic [15:0] dn_tbl [4] = '{16'h0000, 16'h0000, 16'hFFF8, 16'hFFE8};

    chirp_gen #(.STROBE_DIV(7), .SWEEP_LEN(4), .GAP_LEN(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(cont),
        .rate_in(rate), .rom(rom_a), .busy(busy_a), .sweep_done(done_a),
        .freq_msb(msb_a), .sweep_count(count_a));

    chirp_gen #(.STROBE_DIV(7), .SWEEP_LEN(8192), .GAP_LEN(64)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop), .continuous(cont),
        .rate_in(rate), .rom(rom_b), .busy(busy_b), .sweep_done(done_b),
        .freq_msb(msb_b), .sweep_count(count_b));

    chirp_gen #(.STROBE_DIV(7), .SWEEP_LEN(4), .GAP_LEN(0)) dut_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(cont),
        .rate_in(rate), .rom(rom_c), .busy(busy_c), .sweep_done(done_c),
        .freq_msb(msb_c), .sweep_count(count_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Start is accepted on the edge inside this tick: that edge is cycle 0.
    task automatic begin_a();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [15:0] model_phase(input int n);
        longint unsigned tri_n;
        longint unsigned prod;
        tri_n = longint'(n) * longint'(n - 1) / 2;
        prod  = tri_n * longint'(DEFAULT_RATE);
        return prod[47:32];
    endfunction

    initial begin
        logic exp_v;
        int   idx;
        int   msb_rise;

        // Reset state
        do_reset();
        check("rst_busy", busy_a, 0);
        check("rst_valid", rom_a.phase_tvalid, 0);
        check("rst_data", rom_a.phase_tdata, 0);
        check("rst_done", done_a, 0);
        check("rst_msb", msb_a, 0);
        check("rst_count", count_a, 0);
        check("rst_busy_b", busy_b, 0);

        // Single up-sweep; a start with a different rate while busy must be ignored
        cont = 1'b0;
        rate = DEFAULT_RATE;
        begin_a();
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) begin
                start = 1'b1;
                rate  = 48'h1;
            end
            tick();
            start = 1'b0;
            rate  = DEFAULT_RATE;
            exp_v = (i % 7 == 0) && (i <= 28);
            check("t1_valid", rom_a.phase_tvalid, exp_v);
            if (exp_v) check("t1_data", rom_a.phase_tdata, up_tbl[i/7-1]);
            check("t1_done", done_a, i == 29);
            check("t1_busy", busy_a, i < 29);
        end
        check("t1_count", count_a, 1);
        check("t1_hold", rom_a.phase_tdata, 16'h0017);

        // Stop at cycle 16
        do_reset();
        begin_a();
        for (int i = 1; i <= 40; i++) begin
            stop = (i == 17);
            tick();
            stop = 1'b0;
            check("t2_valid", rom_a.phase_tvalid, (i == 7) || (i == 14));
            check("t2_busy", busy_a, i < 17);
            check("t2_done", done_a, 0);
        end
        check("t2_count", count_a, 0);

        // Stop landing on a strobe edge suppresses that sample
        do_reset();
        begin_a();
        for (int i = 1; i <= 20; i++) begin
            stop = (i == 14);
            tick();
            stop = 1'b0;
            check("t2b_valid", rom_a.phase_tvalid, i == 7);
            check("t2b_busy", busy_a, i < 14);
        end

        // Continuous: gap of two strobes (dut_a) and no gap (dut_c)
        do_reset();
        cont = 1'b1;
        begin_a();
        cont = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            exp_v = (i % 7 == 0) && ((i <= 28) || (i >= 49));
            idx   = (i <= 28) ? (i / 7 - 1) : ((i - 49) / 7);
            check("t3_valid_a", rom_a.phase_tvalid, exp_v);
            if (exp_v) check("t3_data_a", rom_a.phase_tdata, up_tbl[idx]);
            check("t3_done_a", done_a, i == 29);
            check("t3_busy_a", busy_a, 1);
            exp_v = (i % 7 == 0);
            check("t3_valid_c", rom_c.phase_tvalid, exp_v);
            if (exp_v) check("t3_data_c", rom_c.phase_tdata, up_tbl[(i/7-1) % 4]);
            check("t3_done_c", done_c, (i == 29) || (i == 57));
            if (i == 30) check("t3_count_a", count_a, 1);
        end
        check("t3_count_c", count_c, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_stop_a", busy_a, 0);
        check("t3_stop_c", busy_c, 0);

        // Reset mid-sweep at cycle 10, restart at cycle 20
        do_reset();
        begin_a();
        for (int i = 1; i <= 27; i++) begin
            rst   = (i == 11);
            start = (i == 20);
            tick();
            rst   = 1'b0;
            start = 1'b0;
            check("t4_valid", rom_a.phase_tvalid, (i == 7) || (i == 27));
            check("t4_busy", busy_a, (i < 11) || (i >= 20));
            check("t4_done", done_a, 0);
            if (i == 11) begin
                check("t4_data", rom_a.phase_tdata, 0);
                check("t4_msb", msb_a, 0);
                check("t4_count", count_a, 0);
            end
        end

        // Start and stop together in IDLE: stop wins
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            start = (i <= 3);
            stop  = (i <= 3);
            tick();
            check("t5_busy", busy_a, 0);
            check("t5_valid", rom_a.phase_tvalid, 0);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Down-chirp with a negative rate
        do_reset();
        rate = -DEFAULT_RATE;
        begin_a();
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_v = (i % 7 == 0) && (i <= 28);
            check("t6_valid", rom_a.phase_tvalid, exp_v);
            if (exp_v) check("t6_data", rom_a.phase_tdata, dn_tbl[i/7-1]);
            check("t6_done", done_a, i == 29);
        end
        rate = DEFAULT_RATE;

        // Full 8192-sample sweep against the closed-form phase model
        do_reset();
        msb_rise = -1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int n = 0; n < 8192; n++) begin
            for (int k = 1; k <= 6; k++) tick();
            check("t7_gap_valid", rom_b.phase_tvalid, 0);
            tick();
            check("t7_valid", rom_b.phase_tvalid, 1);
            check("t7_data", rom_b.phase_tdata, model_phase(n));
            if (msb_b && (msb_rise < 0)) msb_rise = n;
        end
        check("t7_msb_rise", msb_rise, 4096);
        tick();
        check("t7_done", done_b, 1);
        check("t7_count", count_b, 1);
        check("t7_busy", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
